// File: rtl/stream_protocol_checker.sv
// stream_protocol_checker
// Passive monitor for valid/ready streams. Per channel it watches stalled
// beats for payload changes and withdrawn valid, optionally flags stalls that
// last StallTimeout cycles, and keeps saturating beat and stall counters.
// All outputs are registered and there is no path from inputs to outputs.
//
// Handshake rule being checked: once valid is high with ready low (a stall),
// valid must stay high and the payload must stay constant until the cycle in
// which valid && ready (the beat) occurs. ready may move freely.
module stream_protocol_checker #(
    parameter int unsigned NumChan      = 1,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned CntWidth     = 32,
    parameter int unsigned StallTimeout = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic [NumChan-1:0]            valid_i,
    input  logic [NumChan-1:0]            ready_i,
    input  logic [NumChan*DataWidth-1:0]  data_i,
    output logic [NumChan-1:0]            err_data_o,
    output logic [NumChan-1:0]            err_valid_o,
    output logic [NumChan-1:0]            err_timeout_o,
    output logic                          err_o,
    output logic                          irq_o,
    output logic [NumChan*CntWidth-1:0]   beat_cnt_o,
    output logic [NumChan*CntWidth-1:0]   stall_cnt_o
);

    // Run counter only needs to reach StallTimeout; with timeout disabled it
    // is kept as a single bit that never leaves 0.
    localparam int unsigned RunWidth = (StallTimeout > 0) ? $clog2(StallTimeout + 1) : 1;
    localparam logic [RunWidth-1:0] RunMax = RunWidth'(StallTimeout);
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
    localparam bit TimeoutEn = (StallTimeout > 0);

    logic [NumChan-1:0]           stall;
    logic [NumChan-1:0]           beat;

    logic [NumChan-1:0]           pending_q, pending_d;
    logic [NumChan*DataWidth-1:0] data_q, data_d;
    logic [NumChan*RunWidth-1:0]  run_q, run_d;
    logic [NumChan-1:0]           err_data_q, err_data_d;
    logic [NumChan-1:0]           err_valid_q, err_valid_d;
    logic [NumChan-1:0]           err_timeout_q, err_timeout_d;
    logic [NumChan*CntWidth-1:0]  beat_cnt_q, beat_cnt_d;
    logic [NumChan*CntWidth-1:0]  stall_cnt_q, stall_cnt_d;
    logic                         err_q, err_d;
    logic                         irq_q, irq_d;

    assign stall = valid_i & ~ready_i;
    assign beat  = valid_i & ready_i;

    // Next-state for stall tracking, violation flags, counters and interrupt.
    always_comb begin
        pending_d     = pending_q;
        data_d        = data_q;
        run_d         = run_q;
        err_data_d    = err_data_q;
        err_valid_d   = err_valid_q;
        err_timeout_d = err_timeout_q;
        beat_cnt_d    = beat_cnt_q;
        stall_cnt_d   = stall_cnt_q;

        for (int c = 0; c < NumChan; c++) begin
            // Stall tracking keeps running through clear_i so that a
            // violation right after a clear is still caught.
            pending_d[c] = stall[c];
            if (stall[c]) begin
                data_d[c*DataWidth +: DataWidth] = data_i[c*DataWidth +: DataWidth];
            end
            if (!stall[c]) begin
                run_d[c*RunWidth +: RunWidth] = '0;
            end else if (run_q[c*RunWidth +: RunWidth] != RunMax) begin
                run_d[c*RunWidth +: RunWidth] = run_q[c*RunWidth +: RunWidth] + RunWidth'(1);
            end

            if (clear_i) begin
                err_data_d[c]                        = 1'b0;
                err_valid_d[c]                       = 1'b0;
                err_timeout_d[c]                     = 1'b0;
                beat_cnt_d[c*CntWidth +: CntWidth]   = '0;
                stall_cnt_d[c*CntWidth +: CntWidth]  = '0;
            end else begin
                if (pending_q[c] && !valid_i[c]) begin
                    err_valid_d[c] = 1'b1;
                end
                if (pending_q[c] && valid_i[c] &&
                    (data_i[c*DataWidth +: DataWidth] != data_q[c*DataWidth +: DataWidth])) begin
                    err_data_d[c] = 1'b1;
                end
                // Fires only on the stall that brings the run to saturation.
                if (TimeoutEn && stall[c] &&
                    (run_q[c*RunWidth +: RunWidth] != RunMax) &&
                    (run_q[c*RunWidth +: RunWidth] + RunWidth'(1) == RunMax)) begin
                    err_timeout_d[c] = 1'b1;
                end
                if (beat[c] && (beat_cnt_q[c*CntWidth +: CntWidth] != CntMax)) begin
                    beat_cnt_d[c*CntWidth +: CntWidth] = beat_cnt_q[c*CntWidth +: CntWidth] + CntWidth'(1);
                end
                if (stall[c] && (stall_cnt_q[c*CntWidth +: CntWidth] != CntMax)) begin
                    stall_cnt_d[c*CntWidth +: CntWidth] = stall_cnt_q[c*CntWidth +: CntWidth] + CntWidth'(1);
                end
            end
        end

        err_d = |{err_data_d, err_valid_d, err_timeout_d};
        irq_d = err_d && !err_q;
    end

    // State registers; everything clears asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q     <= '0;
            data_q        <= '0;
            run_q         <= '0;
            err_data_q    <= '0;
            err_valid_q   <= '0;
            err_timeout_q <= '0;
            beat_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            err_q         <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            data_q        <= data_d;
            run_q         <= run_d;
            err_data_q    <= err_data_d;
            err_valid_q   <= err_valid_d;
            err_timeout_q <= err_timeout_d;
            beat_cnt_q    <= beat_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            err_q         <= err_d;
            irq_q         <= irq_d;
        end
    end

    assign err_data_o    = err_data_q;
    assign err_valid_o   = err_valid_q;
    assign err_timeout_o = err_timeout_q;
    assign err_o         = err_q;
    assign irq_o         = irq_q;
    assign beat_cnt_o    = beat_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/stream_protocol_checker.md
# stream_protocol_checker

- Synthesizable, multi-channel monitor for valid/ready streams with AXI handshake rules.
- Per channel, it detects two protocol violations while a beat is stalled: the payload changes, or valid is withdrawn before the handshake.
- It also flags stalls that exceed a configurable timeout, and keeps saturating beat and stall counters.
- It sits passively beside any stream link (silicon debug, FPGA bring-up, or simulation without SVA) and drives sticky error flags plus a one-cycle interrupt pulse.

## Interface
- NumChan, 1: number of monitored streams, ≥1.
- DataWidth, 32: payload width per channel, ≥1.
- CntWidth, 32: width of each beat and stall counter, ≥2.
- StallTimeout, 0: number of consecutive stalled cycles that raises a timeout; 0 disables timeout checking.
- clk_i  input  1  clock; everything is sampled on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous clear of all sticky flags and counters.
- valid_i  input  NumChan  valid per channel.
- ready_i  input  NumChan  ready per channel.
- data_i  input  NumChan*DataWidth  payloads, flattened; channel c occupies bits [c*DataWidth +: DataWidth].
- err_data_o  output  NumChan  sticky: payload changed while a beat was stalled.
- err_valid_o  output  NumChan  sticky: valid dropped while a beat was stalled.
- err_timeout_o  output  NumChan  sticky: stall lasted StallTimeout cycles.
- err_o  output  1  OR of all sticky flags.
- irq_o  output  1  one-cycle pulse when err_o rises.
- beat_cnt_o  output  NumChan*CntWidth  handshakes (valid&&ready) per channel, saturating.
- stall_cnt_o  output  NumChan*CntWidth  cycles with valid&&!ready per channel, saturating.

## Operation
- Per-channel state:
  - pending_q: the previous cycle had valid&&!ready.
  - data_q: the payload sampled in that stall cycle.
  - run_q: consecutive stall cycles, saturating at StallTimeout.
- Stall cycle (valid&&!ready): set pending_q, load data_q with data_i, increment run_q and stall_cnt.
- Otherwise: clear pending_q and run_q.
- Checks in cycle N, comparing the cycle-N inputs with the registered state:
  - pending_q && !valid_i → set err_valid.
  - pending_q && valid_i && data_i != data_q → set err_data.
  - The comparison is exact bitwise; X/Z is not treated specially in RTL.
- Timeout (StallTimeout>0 only): when a stall cycle brings run_q to StallTimeout, set err_timeout.
  - The flag is set once per stall episode; run_q holds at saturation.
- Beat counting: valid_i&&ready_i increments beat_cnt.
  - Legal whether or not the beat was previously stalled.
  - ready may rise or fall freely without valid; this is not an error.
- Saturation: counters stick at 2^CntWidth-1 and never wrap.
- Multiple violations in the same cycle on the same channel set all applicable flags.
- Channels are fully independent.
- Sticky flags stay set until clear_i or reset.
- clear_i priority:
  - In a cycle with clear_i high, all flags and counters go to 0.
  - Any violation, beat or stall in that same cycle is discarded.
  - pending_q, data_q and run_q still update normally, so a violation on the cycle after clear is still detected.
- irq_o: high for exactly one cycle when err_o goes from 0 to 1.
  - It does not re-pulse while err_o stays 1, even if new flags set.
- Reset (asynchronous, any time, including mid-stall):
  - All state to 0: pending_q, data_q, run_q, counters, flags, irq_o.
  - Outputs are 0 immediately on rst_ni low.
  - A stall in progress at reset is forgotten, so no error is raised when valid drops after reset.

## Timing
- Every output is registered; all outputs reset to 0.
- Violation in cycle N → flag high from cycle N+1; irq_o high in N+1 only.
- Handshake or stall in cycle N → counter shows the new value in N+1.
- Timeout: a stall starting in cycle S with ready low throughout → err_timeout high in cycle S+StallTimeout.
- No combinational path from inputs to outputs.
- No handshake is generated: the block has no ready/valid outputs.

## Test plan
- Legal traffic, NumChan=2, StallTimeout=4:
  - ch0 holds valid with data 0xA5 through 3 stall cycles, then handshakes.
  - Required: no flags set, beat_cnt[0]=1, stall_cnt[0]=3.
- Data change, ch1:
  - Stalls with 0x10, changes to 0x11 the next cycle.
  - Required: err_data_o[1]=1 exactly one cycle after the change, irq_o pulses once, err_data_o[0]=0.
- Valid drop:
  - Stall one cycle, then valid=0.
  - Required: err_valid_o=1 next cycle.
  - A second drop after clear_i shows err_valid re-set and a second irq_o pulse.
- Timeout, StallTimeout=4:
  - Stall for 4 cycles → err_timeout_o high on cycle S+4.
  - Stall for 3 cycles then handshake → no flag.
  - With StallTimeout=0, a 100-cycle stall → no flag.
- Saturation and clear, CntWidth=2:
  - 5 handshakes → beat_cnt=3.
  - clear_i asserted during a handshake → beat_cnt=0 next cycle, that beat not counted.
- Async reset mid-stall:
  - rst_ni low for half a cycle during a stall → all outputs 0 immediately.
  - valid dropping after reset release → no err_valid.
